// File: rtl/led_seq_ctrl.sv
// LED counter sequencer: walks a divider table, acknowledges each LED
// interrupt, holds a step for its dwell count, then advances or loops.
module led_seq_ctrl #(
    parameter  int NUM_STEPS = 8,
    parameter  int DWELL_W   = 8,
    parameter  int CLR_TMO   = 15,
    localparam int ADDR_W    = $clog2(NUM_STEPS)
) (
    input  logic               clk100,
    input  logic               rst,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               loop_i,
    input  logic [ADDR_W:0]    num_steps_i,
    input  logic               tbl_we_i,
    input  logic [ADDR_W-1:0]  tbl_addr_i,
    input  logic [11:0]        tbl_div_i,
    input  logic [DWELL_W-1:0] tbl_dwell_i,
    input  logic               led_int_i,
    output logic [11:0]        div_o,
    output logic               wren_o,
    output logic               int_clr_o,
    output logic               busy_o,
    output logic [ADDR_W-1:0]  step_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int TMO_W = $clog2(CLR_TMO + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        ACK,
        WAITC
    } state_t;

    state_t state_q, state_d;

    logic [11:0]        tbl_div   [NUM_STEPS];
    logic [DWELL_W-1:0] tbl_dwell [NUM_STEPS];

    logic [11:0]        div_q, div_d;
    logic               wren_q, wren_d;
    logic               clr_q, clr_d;
    logic               busy_q, busy_d;
    logic [ADDR_W-1:0]  step_q, step_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [ADDR_W:0]    num_q, num_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic [DWELL_W-1:0] dwell_eff;
    logic [ADDR_W:0]    step_ext;
    logic               step_done;
    logic               last_step;

    always_ff @(posedge clk100) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                tbl_div[i]   <= '0;
                tbl_dwell[i] <= '0;
            end
        end else if (tbl_we_i && !busy_q) begin
            tbl_div[tbl_addr_i]   <= tbl_div_i;
            tbl_dwell[tbl_addr_i] <= tbl_dwell_i;
        end
    end

    // A zero dwell entry still needs one interrupt to move on
    assign dwell_eff = (tbl_dwell[step_q] == '0) ? DWELL_W'(1)
                                                 : tbl_dwell[step_q];
    assign step_done = (dwell_q >= dwell_eff);
    assign step_ext  = {1'b0, step_q} + (ADDR_W + 1)'(1);
    assign last_step = (step_ext >= num_q);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        wren_d  = 1'b0;
        clr_d   = 1'b0;
        step_d  = step_q;
        done_d  = 1'b0;
        err_d   = err_q;
        num_d   = num_q;
        dwell_d = dwell_q;
        tmo_d   = tmo_q;
        busy_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    if (num_steps_i != '0) begin
                        num_d   = num_steps_i;
                        step_d  = '0;
                        err_d   = 1'b0;
                        state_d = LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
                if (led_int_i) state_d = ACK;
            end
            ACK: state_d = WAITC;
            WAITC: begin
                if (!led_int_i) begin
                    if (!step_done) begin
                        state_d = RUN;
                    end else if (!last_step) begin
                        step_d  = step_q + ADDR_W'(1);
                        state_d = LOAD;
                    end else if (loop_i) begin
                        step_d  = '0;
                        state_d = LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (tmo_q >= TMO_W'(CLR_TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (stop_i && state_q != IDLE) begin
            state_d = IDLE;
            step_d  = step_q;
            done_d  = 1'b0;
            err_d   = err_q;
        end

        // Strobes are registered on entry so they line up with the state
        if (state_d == LOAD) begin
            div_d   = tbl_div[step_d];
            wren_d  = 1'b1;
            clr_d   = 1'b1;
            dwell_d = '0;
        end
        if (state_d == ACK) begin
            clr_d   = 1'b1;
            dwell_d = dwell_q + DWELL_W'(1);
            tmo_d   = TMO_W'(1);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            wren_q  <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            step_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            num_q   <= '0;
            dwell_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            wren_q  <= wren_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
            done_q  <= done_d;
            err_q   <= err_d;
            num_q   <= num_d;
            dwell_q <= dwell_d;
            tmo_q   <= tmo_d;
        end
    end

    assign div_o     = div_q;
    assign wren_o    = wren_q;
    assign int_clr_o = clr_q;
    assign busy_o    = busy_q;
    assign step_o    = step_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule
